// File: rtl/udp_tx_arbiter.sv
// Packet-atomic 2:1 round-robin merge of the peer and host UDP TX streams into one registered
// output, with sideband capture, declared-size checking and saturating statistics.
module udp_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_axis_peer_valid,
    output logic                  s_axis_peer_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_peer_data,
    input  logic [KEEP_WIDTH-1:0] s_axis_peer_keep,
    input  logic                  s_axis_peer_last,
    input  logic [15:0]           s_axis_peer_src,
    input  logic [15:0]           s_axis_peer_dst,
    input  logic [15:0]           s_axis_peer_size,

    input  logic                  s_axis_host_valid,
    output logic                  s_axis_host_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_host_data,
    input  logic [KEEP_WIDTH-1:0] s_axis_host_keep,
    input  logic                  s_axis_host_last,
    input  logic [15:0]           s_axis_host_src,
    input  logic [15:0]           s_axis_host_dst,
    input  logic [15:0]           s_axis_host_size,

    output logic                  m_axis_tx_valid,
    input  logic                  m_axis_tx_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tx_data,
    output logic [KEEP_WIDTH-1:0] m_axis_tx_keep,
    output logic                  m_axis_tx_last,
    output logic [15:0]           m_axis_tx_src,
    output logic [15:0]           m_axis_tx_dst,
    output logic [15:0]           m_axis_tx_size,

    output logic [CNT_WIDTH-1:0]  stat_peer_pkts,
    output logic [CNT_WIDTH-1:0]  stat_host_pkts,
    output logic [CNT_WIDTH-1:0]  stat_len_err
);

    localparam int unsigned PCNT_WIDTH = $clog2(KEEP_WIDTH + 1);
    localparam logic PortPeer = 1'b0;
    localparam logic PortHost = 1'b1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            first_q, first_d;
    logic [16:0]     acc_q, acc_d;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic                  last_q;
    logic [15:0]           src_q, dst_q, size_q;
    logic [CNT_WIDTH-1:0]  peer_cnt_q, host_cnt_q, err_cnt_q;

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_last;
    logic [15:0]           sel_src, sel_dst, sel_size;
    logic                  out_ready, xfer_ready, beat, pkt_done, len_bad;
    logic [PCNT_WIDTH-1:0] keep_cnt;
    logic [16:0]           byte_sum;
    logic [15:0]           size_ref;

    always_comb begin
        if (grant_q == PortHost) begin
            sel_valid = s_axis_host_valid;
            sel_data  = s_axis_host_data;
            sel_keep  = s_axis_host_keep;
            sel_last  = s_axis_host_last;
            sel_src   = s_axis_host_src;
            sel_dst   = s_axis_host_dst;
            sel_size  = s_axis_host_size;
        end else begin
            sel_valid = s_axis_peer_valid;
            sel_data  = s_axis_peer_data;
            sel_keep  = s_axis_peer_keep;
            sel_last  = s_axis_peer_last;
            sel_src   = s_axis_peer_src;
            sel_dst   = s_axis_peer_dst;
            sel_size  = s_axis_peer_size;
        end
    end

    // No skid buffer: upstream ready follows the output register's ability to load.
    assign out_ready         = !valid_q || m_axis_tx_ready;
    assign xfer_ready        = (state_q == StXfer) && out_ready;
    assign s_axis_peer_ready = xfer_ready && (grant_q == PortPeer);
    assign s_axis_host_ready = xfer_ready && (grant_q == PortHost);
    assign beat              = xfer_ready && sel_valid;
    assign pkt_done          = beat && sel_last;

    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + PCNT_WIDTH'(sel_keep[i]);
        end
    end

    // A single-beat packet has no captured size yet, so compare against the live field.
    assign byte_sum = acc_q + 17'(keep_cnt);
    assign size_ref = first_q ? sel_size : size_q;
    assign len_bad  = byte_sum != {1'b0, size_ref};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        acc_d        = acc_q;
        unique case (state_q)
            StIdle: begin
                if (s_axis_peer_valid || s_axis_host_valid) begin
                    if (s_axis_peer_valid && s_axis_host_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s_axis_host_valid ? PortHost : PortPeer;
                    end
                    state_d = StXfer;
                    first_d = 1'b1;
                    acc_d   = '0;
                end
            end
            StXfer: begin
                if (beat) begin
                    first_d = 1'b0;
                    acc_d   = byte_sum;
                    if (sel_last) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= PortPeer;
            last_grant_q <= PortHost;
            first_q      <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            acc_q        <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            size_q  <= '0;
        end else if (beat) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            keep_q  <= sel_keep;
            last_q  <= sel_last;
            if (first_q) begin
                src_q  <= sel_src;
                dst_q  <= sel_dst;
                size_q <= sel_size;
            end
        end else if (m_axis_tx_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peer_cnt_q <= '0;
            host_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (pkt_done) begin
            if (grant_q == PortPeer && peer_cnt_q != '1) begin
                peer_cnt_q <= peer_cnt_q + CNT_WIDTH'(1);
            end
            if (grant_q == PortHost && host_cnt_q != '1) begin
                host_cnt_q <= host_cnt_q + CNT_WIDTH'(1);
            end
            if (len_bad && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tx_valid = valid_q;
    assign m_axis_tx_data  = data_q;
    assign m_axis_tx_keep  = keep_q;
    assign m_axis_tx_last  = last_q;
    assign m_axis_tx_src   = src_q;
    assign m_axis_tx_dst   = dst_q;
    assign m_axis_tx_size  = size_q;
    assign stat_peer_pkts  = peer_cnt_q;
    assign stat_host_pkts  = host_cnt_q;
    assign stat_len_err    = err_cnt_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: arbitration order, bubbles, backpressure, length errors,
// counter saturation and asynchronous reset.
module tb_udp_tx_arbiter;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          peer_valid, peer_ready, peer_last;
    logic [DW-1:0] peer_data;
    logic [KW-1:0] peer_keep;
    logic [15:0]   peer_src, peer_dst, peer_size;
    logic          host_valid, host_ready, host_last;
    logic [DW-1:0] host_data;
    logic [KW-1:0] host_keep;
    logic [15:0]   host_src, host_dst, host_size;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [15:0]   m_src, m_dst, m_size;
    logic [CW-1:0] st_peer, st_host, st_err;

    udp_tx_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_peer_valid (peer_valid),
        .s_axis_peer_ready (peer_ready),
        .s_axis_peer_data  (peer_data),
        .s_axis_peer_keep  (peer_keep),
        .s_axis_peer_last  (peer_last),
        .s_axis_peer_src   (peer_src),
        .s_axis_peer_dst   (peer_dst),
        .s_axis_peer_size  (peer_size),
        .s_axis_host_valid (host_valid),
        .s_axis_host_ready (host_ready),
        .s_axis_host_data  (host_data),
        .s_axis_host_keep  (host_keep),
        .s_axis_host_last  (host_last),
        .s_axis_host_src   (host_src),
        .s_axis_host_dst   (host_dst),
        .s_axis_host_size  (host_size),
        .m_axis_tx_valid   (m_valid),
        .m_axis_tx_ready   (m_ready),
        .m_axis_tx_data    (m_data),
        .m_axis_tx_keep    (m_keep),
        .m_axis_tx_last    (m_last),
        .m_axis_tx_src     (m_src),
        .m_axis_tx_dst     (m_dst),
        .m_axis_tx_size    (m_size),
        .stat_peer_pkts    (st_peer),
        .stat_host_pkts    (st_host),
        .stat_len_err      (st_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] keep;
        logic        last;
        logic [15:0] src, dst, size;
        int          cyc;
    } beat_t;

    beat_t       out_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        excl_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] snap_lo, snap_keep, snap_side;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input int port, input logic [7:0] tag, input int b);
        return {16'hCAFE, 8'(port), tag, 8'(b), 24'h5A5A5A};
    endfunction

    function automatic logic port_ready(input int port);
        return (port == 0) ? peer_ready : host_ready;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records transfers and checks the register holds still while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data", m_data[63:0], snap_lo);
                check("stall_keep", m_keep, snap_keep);
                check("stall_side", 64'({m_src, m_dst, m_size, m_last}), snap_side);
            end
            if (m_valid && m_ready) begin
                beat_t r;
                r.lo = m_data[63:0];
                r.hi = m_data[DW-1:DW-64];
                r.keep = m_keep;
                r.last = m_last;
                r.src = m_src;
                r.dst = m_dst;
                r.size = m_size;
                r.cyc = cyc;
                out_q.push_back(r);
            end
            stall_prev = m_valid && !m_ready;
            snap_lo    = m_data[63:0];
            snap_keep  = m_keep;
            snap_side  = 64'({m_src, m_dst, m_size, m_last});
            if (excl_en) check("ready_excl", 64'(peer_ready & host_ready), 64'd0);
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drive_pkt(input int port, input logic [7:0] tag, input int nb,
                             input logic [63:0] lkeep, input logic [15:0] size,
                             input logic [15:0] src, input logic [15:0] dst);
        for (int b = 0; b < nb; b++) begin
            logic [63:0] w, k;
            logic        l;
            logic [15:0] ss, sd, sz;
            int          n;
            w  = mk_word(port, tag, b);
            k  = (b == nb - 1) ? lkeep : {64{1'b1}};
            l  = (b == nb - 1);
            // Non-first beats carry junk sideband, which must be ignored.
            ss = (b == 0) ? src : ~src;
            sd = (b == 0) ? dst : ~dst;
            sz = (b == 0) ? size : ~size;
            if (port == 0) begin
                peer_valid = 1'b1; peer_data = {8{w}}; peer_keep = k; peer_last = l;
                peer_src = ss; peer_dst = sd; peer_size = sz;
            end else begin
                host_valid = 1'b1; host_data = {8{w}}; host_keep = k; host_last = l;
                host_src = ss; host_dst = sd; host_size = sz;
            end
            n = 0;
            @(negedge clk);
            while (!port_ready(port) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                check("drive_timeout", 64'd0, 64'd1);
                if (port == 0) peer_valid = 1'b0; else host_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (port == 0) peer_valid = 1'b0; else host_valid = 1'b0;
    endtask

    task automatic expect_pkt(input int port, input logic [7:0] tag, input int nb,
                              input logic [63:0] lkeep, input logic [15:0] size,
                              input logic [15:0] src, input logic [15:0] dst,
                              output int first_cyc, output int last_cyc);
        first_cyc = -100;
        last_cyc  = -100;
        for (int b = 0; b < nb; b++) begin
            beat_t       r;
            logic [63:0] w;
            w = mk_word(port, tag, b);
            if (out_q.size() == 0) begin
                check("beat_missing", 64'd0, 64'd1);
                return;
            end
            r = out_q.pop_front();
            check("data_lo", r.lo, w);
            check("data_hi", r.hi, w);
            check("keep", r.keep, (b == nb - 1) ? lkeep : {64{1'b1}});
            check("last", 64'(r.last), 64'(b == nb - 1));
            check("src", 64'(r.src), 64'(src));
            check("dst", 64'(r.dst), 64'(dst));
            check("size", 64'(r.size), 64'(size));
            if (b == 0) first_cyc = r.cyc;
            last_cyc = r.cyc;
        end
    endtask

    task automatic clear_inputs();
        peer_valid = 1'b0; peer_data = '0; peer_keep = '0; peer_last = 1'b0;
        peer_src = '0; peer_dst = '0; peer_size = '0;
        host_valid = 1'b0; host_data = '0; host_keep = '0; host_last = 1'b0;
        host_src = '0; host_dst = '0; host_size = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_q.delete();
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, fa, la, fb, lb, fc, lc, fd, ld, wait_n;
        rst = 1'b1;
        m_ready = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", m_data[63:0], 64'd0);
        check("rst_keep", m_keep, 64'd0);
        check("rst_side", 64'({m_src, m_dst, m_size, m_last}), 64'd0);
        check("rst_ready", 64'({peer_ready, host_ready}), 64'd0);
        check("rst_stats", 64'({st_peer, st_host, st_err}), 64'd0);
        rst = 1'b0;

        // Single 3-beat peer packet, 64+64+8 = 136 bytes.
        @(posedge clk); #1;
        t0 = cyc;
        drive_pkt(0, 8'h01, 3, 64'hFF, 16'd136, 16'h1111, 16'h2222);
        drain();
        expect_pkt(0, 8'h01, 3, 64'hFF, 16'd136, 16'h1111, 16'h2222, fa, la);
        check("first_latency", 64'(fa - t0), 64'd2);
        check("t1_peer", 64'(st_peer), 64'd1);
        check("t1_host", 64'(st_host), 64'd0);
        check("t1_err", 64'(st_err), 64'd0);
        check("t1_extra", 64'(out_q.size()), 64'd0);

        // Both valid from reset: peer, host, peer, host with one bubble between packets.
        do_reset();
        @(posedge clk); #1;
        fork
            begin
                drive_pkt(0, 8'h10, 2, {64{1'b1}}, 16'd128, 16'h0A0A, 16'h0B0B);
                drive_pkt(0, 8'h12, 2, {64{1'b1}}, 16'd128, 16'h0A0C, 16'h0B0C);
            end
            begin
                drive_pkt(1, 8'h11, 1, {64{1'b1}}, 16'd64, 16'h0C0C, 16'h0D0D);
                drive_pkt(1, 8'h13, 1, {64{1'b1}}, 16'd64, 16'h0C0E, 16'h0D0E);
            end
        join
        drain();
        expect_pkt(0, 8'h10, 2, {64{1'b1}}, 16'd128, 16'h0A0A, 16'h0B0B, fa, la);
        expect_pkt(1, 8'h11, 1, {64{1'b1}}, 16'd64, 16'h0C0C, 16'h0D0D, fb, lb);
        expect_pkt(0, 8'h12, 2, {64{1'b1}}, 16'd128, 16'h0A0C, 16'h0B0C, fc, lc);
        expect_pkt(1, 8'h13, 1, {64{1'b1}}, 16'd64, 16'h0C0E, 16'h0D0E, fd, ld);
        check("gap_ab", 64'(fb - la), 64'd2);
        check("gap_bc", 64'(fc - lb), 64'd2);
        check("gap_cd", 64'(fd - lc), 64'd2);
        check("t2_stats", 64'({st_peer, st_host, st_err}), 64'({4'd2, 4'd2, 4'd0}));
        check("t2_extra", 64'(out_q.size()), 64'd0);

        // Backpressure mid-packet with the host waiting.
        do_reset();
        excl_en = 1'b1;
        @(posedge clk); #1;
        fork
            drive_pkt(0, 8'h20, 4, {64{1'b1}}, 16'd256, 16'h2020, 16'h2121);
            drive_pkt(1, 8'h21, 1, {64{1'b1}}, 16'd64, 16'h2222, 16'h2323);
            begin
                wait_n = 0;
                while (out_q.size() == 0 && wait_n < 50) begin
                    @(negedge clk);
                    wait_n++;
                end
                @(posedge clk); #1; m_ready = 1'b0;
                @(posedge clk); #1; m_ready = 1'b0;
                @(posedge clk); #1; m_ready = 1'b1;
            end
        join
        drain();
        excl_en = 1'b0;
        expect_pkt(0, 8'h20, 4, {64{1'b1}}, 16'd256, 16'h2020, 16'h2121, fa, la);
        expect_pkt(1, 8'h21, 1, {64{1'b1}}, 16'd64, 16'h2222, 16'h2323, fb, lb);
        check("t3_stats", 64'({st_peer, st_host, st_err}), 64'({4'd1, 4'd1, 4'd0}));
        check("t3_extra", 64'(out_q.size()), 64'd0);

        // Host single beat with 16 bytes but size 20.
        do_reset();
        @(posedge clk); #1;
        drive_pkt(1, 8'h30, 1, 64'hFFFF, 16'd20, 16'h3333, 16'h4444);
        drain();
        expect_pkt(1, 8'h30, 1, 64'hFFFF, 16'd20, 16'h3333, 16'h4444, fa, la);
        check("t4_stats", 64'({st_peer, st_host, st_err}), 64'({4'd0, 4'd1, 4'd1}));

        // Sixteen bad-length host packets saturate 4-bit counters at 0xF.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive_pkt(1, 8'(8'h40 + i), 1, 64'hF, 16'd0, 16'h5555, 16'h6666);
        end
        drain();
        check("sat_host", 64'(st_host), 64'hF);
        check("sat_err", 64'(st_err), 64'hF);
        check("sat_peer", 64'(st_peer), 64'd0);
        check("sat_count", 64'(out_q.size()), 64'd16);

        // Reset during beat 2 of a 4-beat peer packet.
        @(posedge clk); #1;
        peer_valid = 1'b1;
        peer_data = {8{mk_word(0, 8'h50, 0)}};
        peer_keep = {64{1'b1}};
        peer_last = 1'b0;
        peer_size = 16'd256;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_valid", 64'(m_valid), 64'd0);
        check("async_stats", 64'({st_peer, st_host, st_err}), 64'd0);
        check("async_ready", 64'({peer_ready, host_ready}), 64'd0);
        peer_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_q.delete();
        @(posedge clk); #1;
        t0 = cyc;
        drive_pkt(1, 8'h51, 1, {64{1'b1}}, 16'd64, 16'h7777, 16'h8888);
        drain();
        expect_pkt(1, 8'h51, 1, {64{1'b1}}, 16'd64, 16'h7777, 16'h8888, fa, la);
        check("post_rst_latency", 64'(fa - t0), 64'd2);
        check("post_rst_stats", 64'({st_peer, st_host, st_err}), 64'({4'd0, 4'd1, 4'd0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Packet-atomic 2:1 round-robin arbiter that merges the card-to-peer lookup-reply stream and the card-to-host ack stream into the single UDP TX stream. Each input carries UDP sideband fields (src, dst, size) with its packet. The block sits directly downstream of the transmission subsystem's two outbound ports. It registers the merged output, holds sideband fields stable for the whole packet, checks declared size against delivered bytes, and keeps saturating statistics.

## Interface
- DATA_WIDTH, 512, payload beat width in bits
- KEEP_WIDTH, 64, byte-enable width (DATA_WIDTH/8)
- CNT_WIDTH, 32, width of each statistics counter
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- s_axis_peer_valid / _ready  in / out  1  port 0 (card-to-peer) handshake
- s_axis_peer_data  in  DATA_WIDTH  port 0 payload
- s_axis_peer_keep  in  KEEP_WIDTH  port 0 byte enables
- s_axis_peer_last  in  1  port 0 end of packet
- s_axis_peer_src, _dst, _size  in  16 each  port 0 UDP ports and payload byte length; valid on first beat
- s_axis_host_* : same set as port 0, for port 1 (card-to-host)
- m_axis_tx_valid / _ready  out / in  1  merged output handshake
- m_axis_tx_data, _keep, _last  out  DATA_WIDTH, KEEP_WIDTH, 1  merged payload
- m_axis_tx_src, _dst, _size  out  16 each  sideband, constant for the whole packet
- stat_peer_pkts, stat_host_pkts  out  CNT_WIDTH  packets forwarded per port
- stat_len_err  out  CNT_WIDTH  packets whose delivered byte count differs from size

## Operation
- FSM states: IDLE, XFER.
- In IDLE, all s_*_ready are 0 and requests are sampled.
  - One valid: that port is granted.
  - Both valid: the port other than last_grant is granted.
  - Any grant moves the FSM to XFER.
- In XFER:
  - The granted port's ready = !m_axis_tx_valid || m_axis_tx_ready.
  - The other port's ready = 0.
  - Each accepted beat loads the output register.
  - On the first beat of the packet, src/dst/size are captured into the sideband registers.
- When the last beat is accepted, the FSM returns to IDLE, last_grant is set to the granted port, and that port's packet counter increments.
- Byte accumulator (17 bits): cleared at grant. On every accepted beat it adds popcount(keep); keep contiguity is not checked.
  - On the last beat, the sum including that beat is compared to the captured size, zero-extended.
  - On mismatch, stat_len_err increments.
- All counters saturate at all-ones and never wrap.
- Output register: m_axis_tx_valid is set on beat acceptance and cleared when m_axis_tx_ready is high with no new beat loaded. Data, keep, last and sideband are stable while valid && !ready.

## Timing
- Reset values:
  - m_axis_tx_valid = 0; m_axis_tx_data, keep, last, src, dst, size = 0.
  - All s_*_ready = 0; all stat_* = 0.
  - FSM = IDLE; last_grant = host, so peer wins the first tie.
- Latency: valid sampled in IDLE at edge k → grant registered at edge k → first beat registered at edge k+1 → m_axis_tx_valid high after edge k+1.
- Steady state is one beat per cycle while m_axis_tx_ready = 1. There is exactly one idle bubble cycle (the IDLE state) between consecutive packets.
- s_*_ready depends combinationally on m_axis_tx_ready; there is no skid buffer.
- Single-beat packet (last on first beat): XFER lasts one accepted beat, then IDLE.
- A port deasserting valid mid-packet holds the grant; there is no timeout.
- Reset asserted mid-packet:
  - The output drops immediately, valid = 0.
  - Partial state and the accumulator are discarded; counters clear.
  - No resynchronisation: upstream is reset together with this block.
- Sideband and keep on non-first beats are ignored for the capture.

## Test plan
- Single packets: peer 3 beats, keep all-ones then 0x0000_0000_0000_00FF on the last beat, size=136 → 3 output beats, src/dst/size held on all three, stat_peer_pkts=1, stat_len_err=0.
- Simultaneous request: both ports valid from reset → peer packet first, host second. Repeat both valid → alternates peer, host, peer, host. One bubble cycle between packets.
- Backpressure: m_axis_tx_ready toggled 1,0,0,1 mid-packet → no beat lost or duplicated, output stable while stalled, non-granted port ready stays 0.
- Length error: host 1-beat packet with keep=0xFFFF, size=20 → stat_len_err=1, packet still forwarded unchanged.
- Saturation and reset: stat_* preloaded or forced near all-ones (CNT_WIDTH=4, 16 packets) → counter holds at 0xF. Then rst pulsed during beat 2 of a 4-beat packet → m_axis_tx_valid=0 and counters=0 asynchronously, FSM IDLE.
